// File: rtl/bch_128_pkg.sv
// Shared constants, H-column table, encoder parity and FSM states for the shortened
// double-error BCH(144,128) decoder. BCH_128_DEC_DOUBLE_EN enables the SEARCH state.
package bch_128_pkg;

  localparam int K = 128;
  localparam int N = 144;
  localparam int R = 16;

  // Low 16 coefficients of g(x) for BCH(255,239) t=2 (octal 267543); x^16 is implicit.
  localparam logic [R-1:0] G_LOW = 16'h6F63;

  typedef logic [N-1:0][R-1:0] h_tab_t;

  // Column p is x^p mod g(x): unit vectors for the parity positions, encoder
  // parity membership for the data positions.
  function automatic h_tab_t gen_h_cols();
    h_tab_t       tab;
    logic [R-1:0] c;
    c = 16'h0001;
    for (int p = 0; p < N; p++) begin
      tab[p] = c;
      c = c[R-1] ? ((c << 1) ^ G_LOW) : (c << 1);
    end
    return tab;
  endfunction

  localparam h_tab_t H_COL = gen_h_cols();

  function automatic logic [R-1:0] enc_parity(input logic [0:K-1] data);
    logic [R-1:0] par;
    par = '0;
    for (int j = 0; j < K; j++)
      if (data[j]) par ^= H_COL[R+j];
    return par;
  endfunction

`ifdef BCH_128_DEC_DOUBLE_EN
  typedef enum logic [1:0] {IDLE, SYND, SEARCH, DONE} dec_state_t;
`else
  typedef enum logic [1:0] {IDLE, SYND, DONE} dec_state_t;
`endif

endpackage

// File: rtl/bch_144_col_match.sv
// Combinational lookup of a 16-bit vector against all 144 H columns.
module bch_144_col_match
  import bch_128_pkg::*;
(
  input  logic [R-1:0] vec,
  output logic         hit,
  output logic [7:0]   pos
);

  logic [N-1:0] match;

  for (genvar gi = 0; gi < N; gi++) begin : g_cmp
    assign match[gi] = (vec == H_COL[gi]);
  end

  // Columns are distinct, so at most one compare fires.
  always_comb begin
    hit = |match;
    pos = '0;
    for (int p = 0; p < N; p++)
      if (match[p]) pos = 8'(p);
  end

endmodule

// File: rtl/bch_128_dec.sv
// BCH(144,128) decoder: single-error correction in SYND, optional double-error
// search (one candidate per cycle) when BCH_128_DEC_DOUBLE_EN is defined.
module bch_128_dec
  import bch_128_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [0:N-1] i_code,
  output logic [0:K-1] o_data,
  output logic         o_valid,
  output logic [1:0]   o_err_cnt,
  output logic         o_uncorr
);

  dec_state_t   state_reg;
  logic [0:N-1] code_reg;
  logic [R-1:0] rx_par;
  logic [R-1:0] syn;
  logic [R-1:0] match_vec;
  logic         hit;
  logic [7:0]   hit_pos;
  logic [0:K-1] flip_data;

  for (genvar gi = 0; gi < R; gi++) begin : g_rx_par
    assign rx_par[gi] = code_reg[gi];
  end

  assign syn = enc_parity(code_reg[R:N-1]) ^ rx_par;

`ifdef BCH_128_DEC_DOUBLE_EN
  logic [7:0] idx_reg;

  // In SEARCH the matcher sees the residual after removing candidate column idx.
  assign match_vec = (state_reg == SEARCH) ? (syn ^ H_COL[idx_reg]) : syn;

  for (genvar gi = 0; gi < K; gi++) begin : g_flip
    assign flip_data[gi] = hit && ((hit_pos == 8'(R + gi)) ||
                                   (state_reg == SEARCH && idx_reg == 8'(R + gi)));
  end
`else
  assign match_vec = syn;

  for (genvar gi = 0; gi < K; gi++) begin : g_flip
    assign flip_data[gi] = hit && (hit_pos == 8'(R + gi));
  end
`endif

  bch_144_col_match u_match (
    .vec (match_vec),
    .hit (hit),
    .pos (hit_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      code_reg  <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_err_cnt <= 2'd0;
      o_uncorr  <= 1'b0;
      i_ready   <= 1'b1;
`ifdef BCH_128_DEC_DOUBLE_EN
      idx_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            code_reg  <= i_code;
            i_ready   <= 1'b0;
            state_reg <= SYND;
          end
        end
        SYND: begin
          if (syn == '0 || hit) begin
            o_data    <= code_reg[R:N-1] ^ flip_data;
            o_err_cnt <= {1'b0, hit};
            o_uncorr  <= 1'b0;
            o_valid   <= 1'b1;
            state_reg <= DONE;
          end else begin
`ifdef BCH_128_DEC_DOUBLE_EN
            idx_reg   <= '0;
            state_reg <= SEARCH;
`else
            o_data    <= code_reg[R:N-1];
            o_err_cnt <= 2'd0;
            o_uncorr  <= 1'b1;
            o_valid   <= 1'b1;
            state_reg <= DONE;
`endif
          end
        end
`ifdef BCH_128_DEC_DOUBLE_EN
        SEARCH: begin
          if (hit) begin
            o_data    <= code_reg[R:N-1] ^ flip_data;
            o_err_cnt <= 2'd2;
            o_uncorr  <= 1'b0;
            o_valid   <= 1'b1;
            state_reg <= DONE;
          end else if (idx_reg == 8'(N - 1)) begin
            o_data    <= code_reg[R:N-1];
            o_err_cnt <= 2'd0;
            o_uncorr  <= 1'b1;
            o_valid   <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end
`endif
        DONE: begin
          o_valid   <= 1'b0;
          i_ready   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_128_dec.sv
// Self-checking bench for bch_128_dec using a polynomial-division reference model;
// expectations follow BCH_128_DEC_DOUBLE_EN when it is defined for the build.
module tb_bch_128_dec;

  localparam logic [16:0] G_POLY = 17'h16F63;  // octal 267543

  typedef struct {
    logic [0:127] data;
    int           cnt;
    bit           unc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_valid;
  logic         i_ready;
  logic [0:143] i_code;
  logic [0:127] o_data;
  logic         o_valid;
  logic [1:0]   o_err_cnt;
  logic         o_uncorr;

  int n_tests = 0;
  int n_failed = 0;
  int cyc = 0;
  int txn_no = 0;
  logic [15:0] col_tab [144];

  bch_128_dec dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_code    (i_code),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_err_cnt (o_err_cnt),
    .o_uncorr  (o_uncorr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of the codeword polynomial (bit p = coefficient of x^p) modulo g(x).
  function automatic logic [15:0] polymod(input logic [0:143] v);
    logic [0:143] w;
    logic [15:0]  rem;
    w = v;
    for (int p = 143; p >= 16; p--)
      if (w[p])
        for (int k = 0; k <= 16; k++)
          if (G_POLY[k]) w[p-16+k] = ~w[p-16+k];
    for (int k = 0; k < 16; k++) rem[k] = w[k];
    return rem;
  endfunction

  function automatic logic [0:143] encode(input logic [0:127] d);
    logic [0:143] cw;
    logic [15:0]  par;
    cw = {16'h0, d};
    par = polymod(cw);
    for (int k = 0; k < 16; k++) cw[k] = par[k];
    return cw;
  endfunction

  function automatic exp_t model(input logic [0:143] rx);
    exp_t         e;
    logic [15:0]  s;
    logic [0:143] fx;
    bit           found;
    s = polymod(rx);
    fx = rx;
    e.cnt = 0;
    e.unc = 0;
    e.lat = 2;
    found = (s == 16'h0);
    for (int p = 0; p < 144 && !found; p++)
      if (col_tab[p] == s) begin
        fx[p] = ~fx[p];
        e.cnt = 1;
        found = 1;
      end
`ifdef BCH_128_DEC_DOUBLE_EN
    for (int i = 0; i < 144 && !found; i++)
      for (int j = 0; j < 144 && !found; j++)
        if (j != i && (col_tab[i] ^ col_tab[j]) == s) begin
          fx[i] = ~fx[i];
          fx[j] = ~fx[j];
          e.cnt = 2;
          e.lat = 3 + i;
          found = 1;
        end
    if (!found) e.lat = 146;
`endif
    if (!found) e.unc = 1;
    e.data = fx[16:143];
    return e;
  endfunction

  task automatic run_txn(input logic [0:143] rx, input bit hold);
    exp_t e;
    int   acc;
    int   lat;
    int   pulses;
    bit   seen;
    e = model(rx);
    lat = -1;
    @(negedge clk);
    i_code = rx;
    i_valid = 1'b1;
    for (int t = 0; t < 400 && !i_ready; t++) @(negedge clk);
    if (!i_ready) begin
      check("accept_timeout", 0, 1);
      i_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(negedge clk);
    if (!hold) i_valid = 1'b0;
    seen = 0;
    for (int t = 0; t < 300; t++) begin
      if (o_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("o_valid_seen", seen, 1);
    if (seen) begin
      lat = cyc + 1 - acc;
      check("latency", lat, e.lat);
      check("o_data", o_data, e.data);
      check("o_err_cnt", o_err_cnt, e.cnt);
      check("o_uncorr", o_uncorr, e.unc);
      @(negedge clk);
      check("o_valid_one_cycle", o_valid, 0);
      pulses = 0;
      for (int t = 0; t < 4; t++) begin
        if (o_valid) pulses++;
        @(negedge clk);
      end
      check("extra_pulses", pulses, 0);
      check("ready_after_done", i_ready, 1);
    end
    txn_no++;
    $display("[TB] txn %0d: hold=%0b lat=%0d cnt=%0d unc=%0b exp_lat=%0d exp_cnt=%0d",
             txn_no, hold, lat, o_err_cnt, o_uncorr, e.lat, e.cnt);
  endtask

  task automatic reset_during(input logic [0:143] rx, input int off);
    int acc;
    int pulses;
    pulses = 0;
    @(negedge clk);
    check("rst_pre_ready", i_ready, 1);
    i_code = rx;
    i_valid = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    i_valid = 1'b0;
    while (cyc < acc + off) begin
      if (o_valid) pulses++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_err_cnt", o_err_cnt, 0);
    check("rst_o_uncorr", o_uncorr, 0);
    check("rst_i_ready", i_ready, 1);
    for (int t = 0; t < 160; t++) begin
      if (o_valid) pulses++;
      @(negedge clk);
    end
    check("rst_no_pulse", pulses, 0);
    $display("[TB] reset at offset %0d: pulses=%0d", off, pulses);
  endtask

  initial begin
    logic [0:127] base;
    logic [0:127] d;
    logic [0:143] cw;
    logic [0:143] rx;
    logic [0:143] onehot;
    exp_t         e;
    bit           got_unc;
    int           pulses;

    reset = 1'b1;
    i_valid = 1'b0;
    i_code = '0;
    for (int p = 0; p < 144; p++) begin
      onehot = '0;
      onehot[p] = 1'b1;
      col_tab[p] = polymod(onehot);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_data", o_data, 0);
    check("reset_o_err_cnt", o_err_cnt, 0);
    check("reset_o_uncorr", o_uncorr, 0);
    check("reset_i_ready", i_ready, 1);

    // zero codeword
    run_txn('0, 1'b0);

    // single data error at position 20
    base = 128'h0123456789ABCDEF0123456789ABCDEF;
    cw = encode(base);
    rx = cw;
    rx[20] = ~rx[20];
    run_txn(rx, 1'b0);

    // double error at positions 3 and 100, with i_valid held high while busy
    rx = cw;
    rx[3] = ~rx[3];
    rx[100] = ~rx[100];
    run_txn(rx, 1'b1);

    // uncorrectable pattern chosen by the model
    got_unc = 0;
    for (int t = 0; t < 50 && !got_unc; t++) begin
      rx = cw;
      for (int k = 0; k < 3; k++) begin
        int p;
        p = $urandom_range(16, 143);
        rx[p] = ~rx[p];
      end
      e = model(rx);
      got_unc = e.unc;
    end
    check("found_uncorr_pattern", got_unc, 1);
    if (got_unc) run_txn(rx, 1'b0);

    // reset in flight, then a clean decode
    rx = cw;
    rx[80] = ~rx[80];
    rx[120] = ~rx[120];
`ifdef BCH_128_DEC_DOUBLE_EN
    reset_during(rx, 51);
`else
    reset_during(rx, 0);
`endif
    run_txn(rx, 1'b0);

    // reset coincident with an accept wins
    @(negedge clk);
    i_code = cw;
    i_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    i_valid = 1'b0;
    check("rst_prio_ready", i_ready, 1);
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      if (o_valid) pulses++;
      @(negedge clk);
    end
    check("rst_prio_no_pulse", pulses, 0);

    // randomized words with 0..3 random bit errors
    for (int n = 0; n < 16; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      rx = encode(d);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        int p;
        p = $urandom_range(0, 143);
        rx[p] = ~rx[p];
      end
      run_txn(rx, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
